// File: rtl/nand_cpu_pkg.sv
// Shared CPU types: branch predictor counter encoding and BTB entry layout.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

package nand_cpu_pkg;
  localparam int BP_PC_W  = `PC_SIZE;
  // Worst-case tag width (ENTRIES >= 2); narrower tags are zero-extended.
  localparam int BP_TAG_W = `PC_SIZE - 1;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_STRONG_NT = 2'b00;
  localparam bp_ctr_t BP_WEAK_NT   = 2'b01;
  localparam bp_ctr_t BP_WEAK_T    = 2'b10;
  localparam bp_ctr_t BP_STRONG_T  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_PC_W-1:0]  target;
    bp_ctr_t             ctr;
  } btb_entry_t;

  function automatic bp_ctr_t bp_ctr_upd(bp_ctr_t c, logic taken);
    if (taken) return (c == BP_STRONG_T) ? c : c + 2'd1;
    return (c == BP_STRONG_NT) ? c : c - 2'd1;
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// Prediction (toward decode) and resolved-branch feedback bundles.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

interface bp_pred_if #(parameter int PC_W = `PC_SIZE);
  logic            pc_override;
  logic [PC_W-1:0] target;
  logic            predict_taken;
  logic [PC_W-1:0] pred_pc;
  modport master(output pc_override, target, predict_taken, pred_pc);
  modport slave (input  pc_override, target, predict_taken, pred_pc);
endinterface

interface bp_fb_if #(parameter int PC_W = `PC_SIZE);
  logic            valid;
  logic [PC_W-1:0] pc;
  logic            feedback_taken;
  logic [PC_W-1:0] feedback_target;
  modport master(output valid, pc, feedback_taken, feedback_target);
  modport slave (input  valid, pc, feedback_taken, feedback_target);
endinterface

// File: rtl/branch_predictor_btb_table.sv
// Direct-mapped BTB storage: async-reset array, combinational lookup, train/allocate write.
module btb_table
  import nand_cpu_pkg::*;
#(
  parameter int PC_W    = BP_PC_W,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = PC_W - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic             rd_taken_o,
  output logic [PC_W-1:0]  rd_target_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             wr_taken_i,
  input  logic [PC_W-1:0]  wr_target_i
);
  btb_entry_t mem_q [ENTRIES];
  btb_entry_t rd_cur, wr_cur, wr_d;
  logic       rd_hit, wr_hit;
  logic       unused_ctr_lsb;

  assign rd_cur         = mem_q[rd_idx_i];
  assign rd_hit         = rd_cur.valid && (rd_cur.tag == BP_TAG_W'(rd_tag_i));
  assign rd_taken_o     = rd_hit && rd_cur.ctr[1];
  assign rd_target_o    = rd_hit ? PC_W'(rd_cur.target) : '0;
  assign unused_ctr_lsb = rd_cur.ctr[0];

  assign wr_cur = mem_q[wr_idx_i];
  assign wr_hit = wr_cur.valid && (wr_cur.tag == BP_TAG_W'(wr_tag_i));

  // Not-taken misses leave the entry alone so a cold branch never evicts a live one.
  always_comb begin
    wr_d = wr_cur;
    if (wr_taken_i) begin
      if (wr_hit) begin
        wr_d.ctr    = bp_ctr_upd(wr_cur.ctr, 1'b1);
        wr_d.target = BP_PC_W'(wr_target_i);
      end else begin
        wr_d = '{valid: 1'b1, tag: BP_TAG_W'(wr_tag_i),
                 target: BP_PC_W'(wr_target_i), ctr: BP_WEAK_T};
      end
    end else if (wr_hit) begin
      wr_d.ctr = bp_ctr_upd(wr_cur.ctr, 1'b0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BP_WEAK_NT};
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_d;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// BTB-based branch predictor: PC split, registered prediction toward decode, stall/flush.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

module branch_predictor
  import nand_cpu_pkg::*;
#(
  parameter int PC_W    = `PC_SIZE,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_fetch_valid,
  input  logic [PC_W-1:0] i_fetch_pc,
  input  logic            i_stall,
  input  logic            i_flush,
  bp_pred_if.master       o_bp,
  bp_fb_if.slave          i_fb
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  logic            lk_taken;
  logic [PC_W-1:0] lk_target;

  logic            pred_valid_q, pred_valid_d;
  logic            pred_taken_q, pred_taken_d;
  logic [PC_W-1:0] pred_target_q, pred_target_d;
  logic [PC_W-1:0] pred_pc_q, pred_pc_d;

  btb_table #(.PC_W(PC_W), .ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (i_fetch_pc[IDX_W-1:0]),
    .rd_tag_i    (i_fetch_pc[PC_W-1:IDX_W]),
    .rd_taken_o  (lk_taken),
    .rd_target_o (lk_target),
    .wr_en_i     (i_fb.valid),
    .wr_idx_i    (i_fb.pc[IDX_W-1:0]),
    .wr_tag_i    (i_fb.pc[PC_W-1:IDX_W]),
    .wr_taken_i  (i_fb.feedback_taken),
    .wr_target_i (i_fb.feedback_target)
  );

  // Flush only kills validity; payload fields keep their last value.
  always_comb begin
    pred_valid_d  = pred_valid_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    pred_pc_d     = pred_pc_q;
    if (i_flush) begin
      pred_valid_d = 1'b0;
    end else if (!i_stall) begin
      pred_valid_d  = i_fetch_valid;
      pred_taken_d  = lk_taken;
      pred_target_d = lk_target;
      pred_pc_d     = i_fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_pc_q     <= '0;
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      pred_pc_q     <= pred_pc_d;
    end
  end

  assign o_bp.pc_override   = pred_valid_q && pred_taken_q;
  assign o_bp.predict_taken = pred_valid_q && pred_taken_q;
  assign o_bp.target        = pred_target_q;
  assign o_bp.pred_pc       = pred_pc_q;
endmodule
